fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Instruction fetch front end for the single-cycle processor. It owns the architectural PC register and consumes the next-PC value that the branch logic produces. It issues one instruction-memory read at a time over a valid/ready handshake and hands each returned instruction, tagged with its PC, to decode over a second valid/ready handshake. Taken branches arrive as a redirect that replaces the sequential PC and squashes any wrong-path fetch.

## Interface
- RESET_PC, 64'h0, PC loaded on reset; bits [1:0] must be zero.
- ADDR_W, 64, PC and address width.
- INSTR_W, 32, instruction width.

- CLK  in  1  rising-edge clock.
- ResetL  in  1  reset; one clock, reset asynchronous, active-low.
- Redirect  in  1  taken-branch pulse from next-PC logic.
- RedirectPC  in  ADDR_W  target PC; sampled when Redirect=1.
- IMemReqValid  out  1  read request valid.
- IMemReqReady  in  1  memory accepts request.
- IMemReqAddr  out  ADDR_W  read address.
- IMemRspValid  in  1  read data valid; earliest one cycle after accept.
- IMemRspData  in  INSTR_W  read data.
- InstrValid  out  1  instruction available to decode.
- InstrReady  in  1  decode accepts instruction.
- Instruction  out  INSTR_W  fetched instruction.
- InstrPC  out  ADDR_W  PC of Instruction.

## Operation
- Registers: PC, InflightPC, Discard flag, output register (Instruction, InstrPC), state.
- States: REQ, WAIT, HOLD.
- REQ:
  - IMemReqValid=1; IMemReqAddr=PC.
  - On IMemReqReady: InflightPC<=PC, PC<=PC+4, go to WAIT.
- WAIT:
  - IMemReqValid=0.
  - On IMemRspValid with Discard=0: load output register with {IMemRspData, InflightPC}, go to HOLD.
  - On IMemRspValid with Discard=1: drop the data, clear Discard, go to REQ.
- HOLD:
  - InstrValid=1; Instruction and InstrPC are stable until accepted.
  - On InstrReady, go to REQ.
- Redirect, checked in every state; it has priority over PC+4:
  - PC<=RedirectPC with bits [1:0] forced to 0.
  - REQ with no accept: return to REQ; the next request uses the new PC.
  - REQ with IMemReqReady in the same cycle: the issued request is wrong-path. Go to WAIT with Discard=1 and PC=RedirectPC; do not increment.
  - WAIT: set Discard=1, stay in WAIT. If IMemRspValid arrives in the same cycle, drop that data and go to REQ.
  - HOLD: drop the held instruction, deassert InstrValid next cycle, go to REQ. If InstrReady is asserted in the same cycle, the handshake completes; decode owns flushing that instruction.
- Arithmetic: PC+4 is modulo 2^ADDR_W; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.

## Timing
- Reset (async assert, sync deassert edge), values:
  - PC=RESET_PC, state=REQ, Discard=0.
  - Output register=0, InstrValid=0.
  - IMemReqValid=1 in the first cycle after release.
- ResetL low mid-transaction abandons the transaction. A response arriving after reset release is not expected; the memory is reset with the same ResetL.
- All outputs are registered or decoded from state alone. There is no combinational path from any input to any output.
- Throughput is one instruction per 3 cycles minimum: accept, response, decode accept.
- Redirect-to-request latency is 1 cycle. IMemReqAddr equals RedirectPC in the cycle after Redirect, unless a discarded response is still outstanding.
- At most one outstanding memory request.

## Structure
- Shared package fetch_pkg holds:
  - state enum {REQ, WAIT, HOLD}
  - INSTR_BYTES=4
  - RESET_PC default
- Sub-module pc_register: holds PC. Inputs are load-sequential and load-redirect, with redirect priority; async active-low reset to RESET_PC.
- Top level holds the FSM, the Discard flag and the output register.

## Test plan
- Reset with RESET_PC=0x1000, memory always ready with 1-cycle response -> request addresses 0x1000, 0x1004, 0x1008; InstrPC matches each address; InstrValid=0 during reset.
- Decode holds InstrReady=0 for 5 cycles -> Instruction and InstrPC stable, no new request issued; the next request is issued the cycle after InstrReady=1.
- Redirect to 0x2000 in WAIT, then response 0xDEADBEEF -> response discarded, InstrValid stays 0, next IMemReqAddr=0x2000.
- Redirect to 0x3003 in the same cycle as request accept -> wrong-path response dropped, next request address 0x3000.
- PC=0xFFFF_FFFF_FFFF_FFFC fetched -> next request address 0x0.
- ResetL asserted while in WAIT -> outputs return to reset values immediately (async); fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES      = 32'd4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory and decode handshakes of the fetch unit, bundled as one interface.
interface fetch_pc_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) ();

  logic               IMemReqValid;
  logic               IMemReqReady;
  logic [ADDR_W-1:0]  IMemReqAddr;
  logic               IMemRspValid;
  logic [INSTR_W-1:0] IMemRspData;
  logic               InstrValid;
  logic               InstrReady;
  logic [INSTR_W-1:0] Instruction;
  logic [ADDR_W-1:0]  InstrPC;

  modport master (
    output IMemReqValid, IMemReqAddr, InstrValid, Instruction, InstrPC,
    input  IMemReqReady, IMemRspValid, IMemRspData, InstrReady
  );

  modport slave (
    input  IMemReqValid, IMemReqAddr, InstrValid, Instruction, InstrPC,
    output IMemReqReady, IMemRspValid, IMemRspData, InstrReady
  );

endinterface

// File: rtl/fetch_pc_unit_pc_register.sv
// Architectural PC register: sequential advance or word-aligned redirect load.
module pc_register
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              CLK,
  input  logic              ResetL,
  input  logic              load_seq,
  input  logic              load_redir,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // Redirect wins over the sequential increment; the increment wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (load_redir) begin
      pc_d = {redir_pc[ADDR_W-1:2], 2'b00};
    end else if (load_seq) begin
      pc_d = pc_q + ADDR_W'(INSTR_BYTES);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge CLK or negedge ResetL) begin
    if (!ResetL) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: one outstanding I-mem read, wrong-path squash, and a held output for decode.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              CLK,
  input  logic              ResetL,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  fetch_pc_unit_if.master   bus
);

  fetch_state_e       state_d, state_q;
  logic               discard_d, discard_q;
  logic [ADDR_W-1:0]  inflight_pc_d, inflight_pc_q;
  logic [ADDR_W-1:0]  instr_pc_d, instr_pc_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic               load_seq_s;
  logic [ADDR_W-1:0]  pc_s;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .CLK        (CLK),
    .ResetL     (ResetL),
    .load_seq   (load_seq_s),
    .load_redir (Redirect),
    .redir_pc   (RedirectPC),
    .pc         (pc_s)
  );

  // Next-state: a redirect accepted alongside a request marks that request wrong-path.
  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    inflight_pc_d = inflight_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    load_seq_s    = 1'b0;
    case (state_q)
      REQ: begin
        if (bus.IMemReqReady) begin
          state_d       = WAIT;
          inflight_pc_d = pc_s;
          if (Redirect) begin
            discard_d = 1'b1;
          end else begin
            load_seq_s = 1'b1;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (bus.IMemRspValid) begin
          discard_d = 1'b0;
          if (!Redirect && !discard_q) begin
            state_d    = HOLD;
            instr_d    = bus.IMemRspData;
            instr_pc_d = inflight_pc_q;
          end else begin
            state_d = REQ;
          end
        end else if (Redirect) begin
          discard_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (Redirect || bus.InstrReady) begin
          state_d = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d   = REQ;
        discard_d = 1'b0;
      end
    endcase
  end

  // FSM, discard flag, in-flight PC and decode output register.
  always_ff @(posedge CLK or negedge ResetL) begin
    if (!ResetL) begin
      state_q       <= REQ;
      discard_q     <= 1'b0;
      inflight_pc_q <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      inflight_pc_q <= inflight_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign bus.IMemReqValid = (state_q == REQ);
  assign bus.IMemReqAddr  = pc_s;
  assign bus.InstrValid   = (state_q == HOLD);
  assign bus.Instruction  = instr_q;
  assign bus.InstrPC      = instr_pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench: program-order PC model plus randomized memory, decode and redirect traffic.
module tb_fetch_pc_unit;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        CLK = 1'b0;
  logic        ResetL = 1'b0;
  logic        Redirect = 1'b0;
  logic [63:0] RedirectPC = 64'h0;

  fetch_pc_unit_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

  fetch_pc_unit #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(RST_PC)) dut (
    .CLK        (CLK),
    .ResetL     (ResetL),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int deliv_cnt = 0;

  // stimulus knobs
  int          rdy_pct = 100, ir_pct = 100, redir_permil = 0;
  int          lat_min = 1, lat_max = 1;
  bit          redir_req = 1'b0, redir_on_accept = 1'b0;
  logic [63:0] redir_tgt = 64'h0;
  bit          force_v = 1'b0;
  logic [31:0] force_data = 32'h0;

  // memory model
  bit          pend_v = 1'b0, acc_last = 1'b0;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = 64'h0, addr_last = 64'h0;

  // reference model: PCs decode must see, in program order
  logic [63:0] exp_q[$];
  logic [63:0] exp_pc;
  bit          saw_wrap = 1'b0;

  bit          prev_redir = 1'b0, prev_deliv = 1'b0, prev_stall = 1'b0;
  logic [63:0] prev_tgt = 64'h0, prev_ipc = 64'h0;
  logic [31:0] prev_instr = 32'h0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_pend(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK); #2;
      found = pend_v;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s actual=timeout expected=outstanding read", name);
    end
  endtask

  task automatic wait_valid(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK); #2;
      found = bus.InstrValid;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s actual=timeout expected=InstrValid", name);
    end
  endtask

  // Drives memory, decode and redirect inputs on the falling edge.
  initial begin : driver
    bus.IMemReqReady = 1'b0;
    bus.IMemRspValid = 1'b0;
    bus.IMemRspData  = 32'h0;
    bus.InstrReady   = 1'b0;
    forever begin
      @(negedge CLK);
      if (!ResetL) begin
        pend_v = 1'b0; acc_last = 1'b0;
        bus.IMemReqReady = 1'b0; bus.IMemRspValid = 1'b0; bus.InstrReady = 1'b0;
        Redirect = 1'b0;
        continue;
      end
      bus.IMemRspValid = 1'b0;
      if (acc_last) begin
        pend_v = 1'b1; pend_addr = addr_last; acc_last = 1'b0;
        pend_cnt = int'($urandom_range(lat_max, lat_min));
      end
      if (pend_v) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.IMemRspValid = 1'b1;
          bus.IMemRspData  = force_v ? force_data : instr_of(pend_addr);
          force_v = 1'b0; pend_v = 1'b0;
        end
      end
      bus.IMemReqReady = ($urandom_range(99, 0) < rdy_pct);
      bus.InstrReady   = ($urandom_range(99, 0) < ir_pct);
      Redirect = 1'b0;
      if (redir_req) begin
        if (!redir_on_accept || (bus.IMemReqValid && bus.IMemReqReady)) begin
          Redirect = 1'b1; RedirectPC = redir_tgt; redir_req = 1'b0;
        end
      end else if ($urandom_range(999, 0) < redir_permil) begin
        Redirect = 1'b1;
        RedirectPC = {$urandom(), $urandom()};
        if ($urandom_range(3, 0) == 0) RedirectPC = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
      end
      acc_last  = bus.IMemReqValid && bus.IMemReqReady;
      addr_last = bus.IMemReqAddr;
    end
  end

  // Monitor: checks what happened at the last edge and what will transfer at the next one.
  initial begin : monitor
    exp_q.push_back(RST_PC);
    forever begin
      @(negedge CLK); #1;
      if (!ResetL) begin
        exp_q.delete(); exp_q.push_back(RST_PC);
        prev_redir = 1'b0; prev_deliv = 1'b0; prev_stall = 1'b0;
        continue;
      end
      if (prev_redir) begin
        check("valid_after_redirect", bus.InstrValid, 1'b0);
        if (bus.IMemReqValid) check("addr_after_redirect", bus.IMemReqAddr, prev_tgt);
      end else if (prev_deliv) begin
        check("req_after_decode_accept", bus.IMemReqValid, 1'b1);
        check("addr_after_decode_accept", bus.IMemReqAddr, exp_q[0]);
      end
      if (prev_stall) begin
        check("hold_valid", bus.InstrValid, 1'b1);
        check("hold_instr_stable", bus.Instruction, prev_instr);
        check("hold_pc_stable", bus.InstrPC, prev_ipc);
      end
      if (bus.InstrValid) check("no_req_in_hold", bus.IMemReqValid, 1'b0);
      if (bus.IMemReqValid && bus.IMemReqReady)
        check("one_outstanding", pend_v || bus.IMemRspValid, 1'b0);
      prev_deliv = bus.InstrValid && bus.InstrReady;
      if (prev_deliv) begin
        deliv_cnt++;
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
          exp_pc = exp_q.pop_front();
          check("instr_pc", bus.InstrPC, exp_pc);
          check("instr_data", bus.Instruction, instr_of(exp_pc));
          if (exp_pc == 64'h0 && bus.InstrPC == 64'h0) saw_wrap = 1'b1;
          exp_q.push_back(exp_pc + 64'd4);
        end
      end
      prev_stall = bus.InstrValid && !bus.InstrReady && !Redirect;
      prev_instr = bus.Instruction;
      prev_ipc   = bus.InstrPC;
      prev_redir = Redirect;
      prev_tgt   = (RedirectPC / 64'd4) * 64'd4;
      if (Redirect) begin
        exp_q.delete();
        exp_q.push_back(prev_tgt);
      end
    end
  end

  int start_cnt;

  // Test sequence.
  initial begin : main
    ResetL = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    check("rst_req_valid", bus.IMemReqValid, 1'b1);
    check("rst_req_addr", bus.IMemReqAddr, RST_PC);
    check("rst_instr_valid", bus.InstrValid, 1'b0);
    check("rst_instruction", bus.Instruction, 32'h0);
    check("rst_instr_pc", bus.InstrPC, 64'h0);
    @(posedge CLK); #2;
    ResetL = 1'b1;
    start_cnt = deliv_cnt;
    repeat (30) @(negedge CLK);
    #3;
    check("throughput_30_cycles", 64'(deliv_cnt - start_cnt), 64'd10);

    // decode stall
    ir_pct = 0;
    wait_valid("stall_wait_valid");
    repeat (6) @(negedge CLK);
    #2;
    ir_pct = 100;
    repeat (6) @(negedge CLK);

    // redirect while waiting, with the discarded response carrying a marker word
    lat_min = 3; lat_max = 3;
    wait_pend("wait_state_redirect");
    force_data = 32'hDEAD_BEEF; force_v = 1'b1;
    redir_tgt = 64'h2000; redir_on_accept = 1'b0; redir_req = 1'b1;
    start_cnt = deliv_cnt;
    repeat (20) @(negedge CLK);
    #3;
    check("progress_after_wait_redirect", 64'(deliv_cnt > start_cnt), 64'd1);

    // redirect coincident with a request accept
    lat_min = 1; lat_max = 1;
    redir_tgt = 64'h3003; redir_on_accept = 1'b1; redir_req = 1'b1;
    start_cnt = deliv_cnt;
    repeat (20) @(negedge CLK);
    #3;
    check("progress_after_accept_redirect", 64'(deliv_cnt > start_cnt), 64'd1);

    // address wrap
    redir_tgt = 64'hFFFF_FFFF_FFFF_FFF8; redir_on_accept = 1'b0; redir_req = 1'b1;
    repeat (20) @(negedge CLK);
    #3;
    check("pc_wrapped_to_zero", 64'(saw_wrap), 64'd1);

    // asynchronous reset while a read is outstanding
    lat_min = 3; lat_max = 3;
    wait_pend("wait_state_reset");
    @(posedge CLK); #2;
    check("wait_state_no_req", bus.IMemReqValid, 1'b0);
    ResetL = 1'b0;
    #1;
    check("async_rst_req_valid", bus.IMemReqValid, 1'b1);
    check("async_rst_req_addr", bus.IMemReqAddr, RST_PC);
    check("async_rst_instr_valid", bus.InstrValid, 1'b0);
    check("async_rst_instruction", bus.Instruction, 32'h0);
    check("async_rst_instr_pc", bus.InstrPC, 64'h0);
    repeat (2) @(posedge CLK);
    #2;
    ResetL = 1'b1;
    start_cnt = deliv_cnt;
    repeat (20) @(negedge CLK);
    #3;
    check("restart_after_reset", 64'(deliv_cnt > start_cnt), 64'd1);

    // randomized traffic
    lat_min = 1; lat_max = 3; rdy_pct = 70; ir_pct = 60; redir_permil = 50;
    start_cnt = deliv_cnt;
    repeat (3000) @(negedge CLK);
    #3;
    check("random_progress", 64'(deliv_cnt - start_cnt > 50), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
